// File: rtl/memory_mapped_timer_if.sv
// Device-side bus between the memory controller and the machine timer.
// The controller is the master; the timer responds as the slave.
interface memory_mapped_timer_if;
    logic [63:0] address;
    logic [63:0] write_data;
    logic        output_enable;
    logic        write_enable;
    logic        chip_select;
    logic [7:0]  byte_enable;
    logic [63:0] read_data;
    logic        busy;

    modport master (
        output address, write_data, output_enable, write_enable, chip_select, byte_enable,
        input  read_data, busy
    );

    modport slave (
        input  address, write_data, output_enable, write_enable, chip_select, byte_enable,
        output read_data, busy
    );
endinterface

// File: rtl/memory_mapped_timer.sv
// RISC-V machine timer (mtime/mtimecmp) on the controller's device port,
// with a fixed-length busy handshake and a registered level interrupt.
module memory_mapped_timer #(
    parameter int unsigned CLOCK_CYCLES = 1,
    parameter int unsigned BUSY_TIME    = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    memory_mapped_timer_if.slave        bus,
    output logic                        timer_interrupt
);

    localparam int unsigned PsWidth  = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
    localparam int unsigned CntWidth = (BUSY_TIME > 1) ? $clog2(BUSY_TIME) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e                r_state;
    logic [CntWidth-1:0]   r_cnt;
    logic                  r_sel;
    logic                  r_op_wr;
    logic [63:0]           r_wdata;
    logic [7:0]            r_be;
    logic                  r_busy;
    logic [63:0]           r_read_data;
    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic [PsWidth-1:0]    r_prescale;
    logic                  r_irq;

    logic                  w_request;
    logic                  w_tick;
    logic                  w_commit;
    logic [63:0]           w_mask;
    logic [63:0]           w_mtime_inc;
    logic [63:0]           w_mtime_next;
    logic [63:0]           w_cmp_next;
    logic                  w_unused_addr;

    assign w_unused_addr = ^{bus.address[63:4], bus.address[2:0]};

    always_comb begin
        w_request    = bus.chip_select & (bus.output_enable | bus.write_enable);
        w_tick       = (r_prescale == PsWidth'(CLOCK_CYCLES - 1));
        w_commit     = (r_state == StBusy) && (r_cnt == '0);
        w_mask       = '0;
        for (int k = 0; k < 8; k++) begin
            w_mask[8*k +: 8] = {8{r_be[k]}};
        end
        w_mtime_inc  = r_mtime + 64'(w_tick);
        w_mtime_next = w_mtime_inc;
        w_cmp_next   = r_mtimecmp;
        // Unwritten mtime bytes still advance with this cycle's increment.
        if (w_commit && r_op_wr) begin
            if (r_sel) begin
                w_cmp_next = (r_wdata & w_mask) | (r_mtimecmp & ~w_mask);
            end else begin
                w_mtime_next = (r_wdata & w_mask) | (w_mtime_inc & ~w_mask);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_sel       <= 1'b0;
            r_op_wr     <= 1'b0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_busy      <= 1'b0;
            r_read_data <= '0;
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_prescale  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_cmp_next;
            r_irq      <= (r_mtime >= r_mtimecmp);
            unique case (r_state)
                StIdle: begin
                    if (w_request) begin
                        r_sel   <= bus.address[3];
                        r_wdata <= bus.write_data;
                        r_be    <= bus.byte_enable;
                        r_op_wr <= bus.write_enable;
                        r_cnt   <= CntWidth'(BUSY_TIME - 1);
                        r_busy  <= 1'b1;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (r_cnt == '0) begin
                        // Reads see mtime as it stood before this edge's increment.
                        if (!r_op_wr) begin
                            r_read_data <= r_sel ? r_mtimecmp : r_mtime;
                        end
                        r_busy  <= 1'b0;
                        r_state <= StRelease;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StRelease: begin
                    if (!w_request) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.read_data   = r_read_data;
    assign bus.busy        = r_busy;
    assign timer_interrupt = r_irq;

endmodule

// File: tb/tb_memory_mapped_timer.sv
// Randomized directed bench for memory_mapped_timer against an arithmetic
// model: mtime after edge n is an offset plus n / CLOCK_CYCLES.
module tb_memory_mapped_timer;

    localparam int unsigned CC = 4;
    localparam int unsigned BT = 4;

    logic clock;
    logic reset;
    logic timer_interrupt;

    memory_mapped_timer_if bus_if();

    memory_mapped_timer #(
        .CLOCK_CYCLES (CC),
        .BUSY_TIME    (BT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus_if),
        .timer_interrupt (timer_interrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rising edges seen since reset was released.
    int n_edges = 0;
    always @(posedge clock or negedge reset) begin
        if (!reset) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    int checks = 0;
    int errors = 0;

    logic [63:0] m_off, m_cmp, m_rdata, prev_mt, prev_cmp;
    bit          wr_pend, rd_pend;
    int          wr_edge, rd_edge;
    logic        wr_sel, rd_sel;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] expand(input logic [7:0] be);
        logic [63:0] m;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    task automatic model_reset();
        m_off    = '0;
        m_cmp    = '1;
        m_rdata  = '0;
        prev_mt  = '0;
        prev_cmp = '1;
        wr_pend  = 0;
        rd_pend  = 0;
    endtask

    // One cycle: check the interrupt, then advance the model to edge n_edges.
    task automatic tick();
        logic [63:0] mask, inc, x;
        @(negedge clock);
        chk("irq", timer_interrupt, (prev_mt >= prev_cmp));
        if (rd_pend && n_edges == rd_edge) begin
            m_rdata = rd_sel ? prev_cmp : prev_mt;
            rd_pend = 0;
        end
        if (wr_pend && n_edges == wr_edge) begin
            mask = expand(wr_be);
            if (wr_sel) begin
                m_cmp = (wr_data & mask) | (prev_cmp & ~mask);
            end else begin
                inc   = prev_mt + ((n_edges % CC == 0) ? 64'd1 : 64'd0);
                x     = (wr_data & mask) | (inc & ~mask);
                m_off = x - 64'(n_edges / CC);
            end
            wr_pend = 0;
        end
        prev_mt  = m_off + 64'(n_edges / CC);
        prev_cmp = m_cmp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // hold == 0: drop the request once busy falls; else hold it for that many cycles.
    task automatic access(input logic we, input logic oe, input logic [63:0] addr,
                          input logic [63:0] data, input logic [7:0] be, input int hold,
                          output logic [63:0] rd);
        int   c, hi, pulses, cyc;
        logic pb;
        tick();
        bus_if.chip_select   = 1'b1;
        bus_if.output_enable = oe;
        bus_if.write_enable  = we;
        bus_if.address       = addr;
        bus_if.write_data    = data;
        bus_if.byte_enable   = be;
        c = n_edges + 1 + BT;
        if (we) begin
            wr_pend = 1; wr_edge = c; wr_sel = addr[3]; wr_data = data; wr_be = be;
        end else begin
            rd_pend = 1; rd_edge = c; rd_sel = addr[3];
        end
        hi = 0; pulses = 0; pb = 1'b0; rd = 'x;
        for (cyc = 1; cyc <= 60; cyc++) begin
            tick();
            if (bus_if.busy && !pb) pulses++;
            if (bus_if.busy) hi++;
            if (!bus_if.busy && pb) begin
                chk("busy_fall_edge", 64'(n_edges), 64'(c));
                chk("read_data", bus_if.read_data, m_rdata);
                rd = bus_if.read_data;
            end
            pb = bus_if.busy;
            if (hold == 0 && pulses > 0 && !bus_if.busy) break;
            if (hold > 0 && cyc >= hold) break;
        end
        bus_if.chip_select   = 1'b0;
        bus_if.output_enable = 1'b0;
        bus_if.write_enable  = 1'b0;
        chk("busy_pulses", 64'(pulses), 64'd1);
        chk("busy_cycles", 64'(hi), 64'(BT));
    endtask

    localparam logic [63:0] AMtime = 64'h0;
    localparam logic [63:0] ACmp   = 64'h8;

    initial begin
        logic [63:0] r1, r2, rd;
        reset = 1'b0;
        bus_if.chip_select   = 1'b0;
        bus_if.output_enable = 1'b0;
        bus_if.write_enable  = 1'b0;
        bus_if.address       = '0;
        bus_if.write_data    = '0;
        bus_if.byte_enable   = '0;
        model_reset();
        idle(3);
        chk("reset_busy", bus_if.busy, 1'b0);
        chk("reset_rdata", bus_if.read_data, 64'd0);
        reset = 1'b1;

        // Free-running count: two reads 40 cycles apart differ by 10.
        access(1'b0, 1'b1, AMtime, '0, 8'h00, 0, r1);
        idle(40 - BT - 2);
        access(1'b0, 1'b1, AMtime, '0, 8'h00, 0, r2);
        chk("mtime_delta", r2 - r1, 64'd10);

        // Compare register and interrupt rise.
        access(1'b1, 1'b0, ACmp, 64'h20, 8'hFF, 0, rd);
        access(1'b0, 1'b1, ACmp, '0, 8'h00, 0, rd);
        chk("cmp_readback", rd, 64'h20);
        idle(100);
        chk("irq_after_cmp", timer_interrupt, 1'b1);

        // Partial byte write and a zero-mask write.
        access(1'b1, 1'b0, ACmp, '1, 8'hFF, 0, rd);
        access(1'b1, 1'b0, ACmp, 64'h1122334455667788, 8'h0F, 0, rd);
        access(1'b1, 1'b0, ACmp, 64'h0, 8'h00, 0, rd);
        access(1'b0, 1'b1, ACmp, '0, 8'h00, 0, rd);
        chk("cmp_partial", rd, 64'hFFFF_FFFF_5566_7788);

        // mtime wraps through zero.
        access(1'b1, 1'b0, AMtime, '1, 8'hFF, 0, rd);
        idle(2 * CC);
        access(1'b0, 1'b1, AMtime, '0, 8'h00, 0, rd);
        chk("mtime_wrapped_small", 64'(rd < 64'd16), 64'd1);

        // Held request: one pulse each; oe+we acts as a write.
        access(1'b0, 1'b1, AMtime, '0, 8'h00, 20, rd);
        access(1'b1, 1'b1, ACmp, 64'h40, 8'hFF, 20, rd);
        access(1'b0, 1'b1, ACmp, '0, 8'h00, 0, rd);
        chk("cmp_after_oe_we", rd, 64'h40);

        // Randomized accesses.
        for (int i = 0; i < 16; i++) begin
            logic w;
            logic [63:0] a, d;
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            access(w, ~w, a, d, 8'($urandom), 0, rd);
            idle($urandom_range(0, 6));
        end

        // Reset during a write to mtimecmp.
        tick();
        bus_if.chip_select  = 1'b1;
        bus_if.write_enable = 1'b1;
        bus_if.address      = ACmp;
        bus_if.write_data   = 64'h5;
        bus_if.byte_enable  = 8'hFF;
        idle(2);
        chk("busy_mid", bus_if.busy, 1'b1);
        reset = 1'b0;
        bus_if.chip_select  = 1'b0;
        bus_if.write_enable = 1'b0;
        model_reset();
        #1;
        chk("busy_on_reset", bus_if.busy, 1'b0);
        chk("rdata_on_reset", bus_if.read_data, 64'd0);
        chk("irq_on_reset", timer_interrupt, 1'b0);
        tick();
        reset = 1'b1;
        access(1'b0, 1'b1, ACmp, '0, 8'h00, 0, rd);
        chk("cmp_after_reset", rd, '1);
        access(1'b0, 1'b1, AMtime, '0, 8'h00, 0, rd);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
